instr_sequencer: RTL

Program sequencer that drives the 14-bit instruction bus and `write_en3` of the register-file/ALU datapath (`figure`), instead of a bench hand-driving them. It holds a small loadable program buffer and issues one instruction per clock when started. It captures the datapath `result` and flags after each issue and reports completion, so programs run back-to-back at full rate.

---
 rtl/instr_seq_pkg.sv | 42 ++++
 rtl/instr_seq_buffer.sv | 54 +++++
 rtl/instr_sequencer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/instr_seq_pkg.sv
// Shared widths, program-word layout, opcode constants and FSM encoding
// for the instruction sequencer and its program buffer.
package instr_seq_pkg;

  localparam int OP_W    = 2;
  localparam int ADDR_W  = 4;
  localparam int INSTR_W = 14;
  localparam int FLAGS_W = 4;
  localparam int WORD_W  = INSTR_W + 1;
  localparam int DATA_W  = 32;

  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB = 2'b01;
  localparam logic [OP_W-1:0] OP_AND = 2'b10;
  localparam logic [OP_W-1:0] OP_OR  = 2'b11;

  // Position of V inside the datapath {Z,N,C,V} flag vector.
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
  } instr_t;

  typedef struct packed {
    logic   we;
    instr_t instr;
  } prog_word_t;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_t;

  function automatic logic flag_v(input logic [FLAGS_W-1:0] flags);
    return flags[FLAG_V];
  endfunction

endpackage

// File: rtl/instr_seq_buffer.sv
// Program buffer: DEPTH x 15-bit register array filled in order from index 0,
// with occupancy count, clear, full flag and asynchronous read.
module instr_seq_buffer
  import instr_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          wr_en,
  input  prog_word_t    wr_data,
  input  logic          clear,
  input  logic [AW-1:0] rd_idx,
  output prog_word_t    rd_data,
  output logic [AW:0]   count,
  output logic          full
);

  prog_word_t  mem [DEPTH];
  logic [AW:0] count_q;
  logic [AW:0] count_d;
  logic        wr_accept;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign wr_accept = wr_en && !full && !clear;
  assign count     = count_q;
  assign rd_data   = mem[rd_idx];

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (wr_accept) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Contents need no reset; only entries below count are ever issued.
  always_ff @(posedge clock) begin
    if (wr_accept) begin
      mem[count_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer driving the datapath instruction bus and write_en3 from a
// loadable buffer. Define INSTR_SEQ_FLAG_HALT_EN to stop a run when V is captured.
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                load_valid,
  input  logic [WORD_W-1:0]   load_data,
  output logic                load_ready,
  input  logic                clear,
  input  logic                start,
  input  logic                abort,
  input  logic [DATA_W-1:0]   result_in,
  input  logic [FLAGS_W-1:0]  flags_in,
  output logic [INSTR_W-1:0]  instruction,
  output logic                write_en3,
  output logic                issue_valid,
  output logic [AW-1:0]       pc,
  output logic                busy,
  output logic                done,
  output logic                halted,
  output logic [DATA_W-1:0]   last_result,
  output logic [FLAGS_W-1:0]  last_flags
);

  seq_state_t          state_q, state_d;
  logic [AW-1:0]       pc_q, pc_d;
  instr_t              instr_q, instr_d;
  logic                we_q, we_d;
  logic                halted_q, halted_d;
  logic [DATA_W-1:0]   last_result_q, last_result_d;
  logic [FLAGS_W-1:0]  last_flags_q, last_flags_d;

  logic [AW:0]         buf_count;
  logic                buf_full;
  logic                buf_wr;
  logic                buf_clear;
  prog_word_t          rd_word;
  logic [AW-1:0]       rd_idx;
  logic [AW-1:0]       pc_inc;
  logic [AW-1:0]       last_idx;
  logic                load_ready_int;
  logic                halt_hit;

  assign load_ready_int = (state_q == SEQ_IDLE) && !buf_full && !start;
  assign buf_clear      = (state_q == SEQ_IDLE) && clear;
  assign buf_wr         = load_valid && load_ready_int && !clear;

  // The instruction register is loaded one step ahead, so the buffer is read
  // at the index that will be issued next (entry 0 when leaving IDLE).
  assign pc_inc   = pc_q + 1'b1;
  assign rd_idx   = (state_q == SEQ_RUN) ? pc_inc : '0;
  assign last_idx = AW'(buf_count - 1'b1);

`ifdef INSTR_SEQ_FLAG_HALT_EN
  assign halt_hit = flag_v(flags_in);
`else
  assign halt_hit = 1'b0;
`endif

  instr_seq_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buffer (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (buf_wr),
    .wr_data (prog_word_t'(load_data)),
    .clear   (buf_clear),
    .rd_idx  (rd_idx),
    .rd_data (rd_word),
    .count   (buf_count),
    .full    (buf_full)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    we_d          = 1'b0;
    halted_d      = halted_q;
    last_result_d = last_result_q;
    last_flags_d  = last_flags_q;

    case (state_q)
      SEQ_IDLE: begin
        if (start && !clear && (buf_count != '0)) begin
          state_d  = SEQ_RUN;
          pc_d     = '0;
          halted_d = 1'b0;
          instr_d  = rd_word.instr;
          we_d     = rd_word.we;
        end
      end

      SEQ_RUN: begin
        if (abort) begin
          state_d = SEQ_IDLE;
        end else begin
          last_result_d = result_in;
          last_flags_d  = flags_in;
          // Terminal check comes before the increment so pc never wraps.
          if (halt_hit) begin
            state_d  = SEQ_DONE;
            halted_d = 1'b1;
          end else if (pc_q == last_idx) begin
            state_d = SEQ_DONE;
          end else begin
            pc_d    = pc_inc;
            instr_d = rd_word.instr;
            we_d    = rd_word.we;
          end
        end
      end

      SEQ_DONE: begin
        state_d = SEQ_IDLE;
      end

      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= SEQ_IDLE;
      pc_q          <= '0;
      instr_q       <= '0;
      we_q          <= 1'b0;
      halted_q      <= 1'b0;
      last_result_q <= '0;
      last_flags_q  <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      we_q          <= we_d;
      halted_q      <= halted_d;
      last_result_q <= last_result_d;
      last_flags_q  <= last_flags_d;
    end
  end

  assign load_ready  = load_ready_int && reset_n;
  assign instruction = instr_q;
  assign write_en3   = we_q;
  assign issue_valid = (state_q == SEQ_RUN);
  assign busy        = (state_q == SEQ_RUN);
  assign done        = (state_q == SEQ_DONE);
  assign pc          = pc_q;
  assign halted      = halted_q;
  assign last_result = last_result_q;
  assign last_flags  = last_flags_q;

endmodule
